// File: rtl/data_bus_target_pkg.sv
// Shared constants for the cpu32 data-side responder: IO region decode,
// register indices and STATUS bit positions.
package data_bus_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CON_W  = 8;

  localparam logic [3:0] IO_REGION = 4'hF;

  typedef enum logic [1:0] {
    REG_COUNT   = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONDATA = 2'd2,
    REG_RSVD    = 2'd3
  } io_reg_e;

  localparam int unsigned STAT_NOT_FULL  = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_OVERFLOW  = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;
  localparam int unsigned STAT_COUNT_W   = 8;

  function automatic logic is_io_addr(input logic [DATA_W-1:0] addr);
    return addr[31:28] == IO_REGION;
  endfunction

endpackage

// File: rtl/data_bus_target_if.sv
// Core data port plus console byte stream; master = core/sink side,
// slave = data_bus_target.
interface data_bus_target_if;

  logic [31:0] d_addr;
  logic [31:0] d_data_w;
  logic        d_we;
  logic [31:0] d_data_r;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  modport master (
    output d_addr, d_data_w, d_we, con_ready,
    input  d_data_r, con_valid, con_data
  );

  modport slave (
    input  d_addr, d_data_w, d_we, con_ready,
    output d_data_r, con_valid, con_data
  );

endinterface

// File: rtl/data_bus_target_sync_fifo.sv
// Synchronous FIFO with async reset; a pop in the same cycle frees a slot for
// a push. Head holds the last popped entry while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             push_accept_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             pop_en;
  logic             push_en;

  assign pop_en        = pop_i && (count_q != '0);
  assign push_en       = push_i && ((count_q < (AW+1)'(DEPTH)) || pop_en);
  assign push_accept_o = push_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push_en) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  // When full, rd_ptr == wr_ptr: the head is read before the same-cycle push overwrites it.
  assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/data_bus_target.sv
// Data-side responder for cpu32: word RAM, cycle counter and console TX FIFO.
// Define DATA_BUS_TARGET_COUNTER_EN to build the COUNT register; otherwise it reads 0.
module data_bus_target
  import data_bus_pkg::*;
#(
  parameter int unsigned RAM_AW  = 10,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               reset,
  data_bus_target_if.slave   bus
);

  logic              is_io;
  io_reg_e           reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              io_wr;
  logic              con_push;
  logic              con_pop;
  logic              push_accept;
  logic [FIFO_AW:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CON_W-1:0]  fifo_head;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] cnt_rd;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] rdata;
  logic              unused_addr_bits;

  logic [DATA_W-1:0] ram_q [2**RAM_AW];

  assign is_io    = is_io_addr(bus.d_addr);
  assign reg_sel  = io_reg_e'(bus.d_addr[3:2]);
  assign ram_idx  = bus.d_addr[RAM_AW+1:2];
  assign io_wr    = bus.d_we && is_io;
  assign con_push = io_wr && (reg_sel == REG_CONDATA);
  assign con_pop  = bus.con_valid && bus.con_ready;

  assign unused_addr_bits = ^{bus.d_addr[27:RAM_AW+2], bus.d_addr[1:0]};

  // RAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (bus.d_we && !is_io) ram_q[ram_idx] <= bus.d_data_w;
  end

  sync_fifo #(
    .WIDTH (CON_W),
    .AW    (FIFO_AW)
  ) u_con_fifo (
    .clk           (clk),
    .rst           (reset),
    .push_i        (con_push),
    .push_data_i   (bus.d_data_w[CON_W-1:0]),
    .pop_i         (con_pop),
    .push_accept_o (push_accept),
    .count_o       (fifo_count),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .head_o        (fifo_head)
  );

  // Sticky overflow: set by a dropped push, cleared by STATUS write with bit2.
  always_comb begin
    ovf_d = ovf_q;
    if (io_wr && (reg_sel == REG_STATUS) && bus.d_data_w[STAT_OVERFLOW]) ovf_d = 1'b0;
    if (con_push && !push_accept) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

`ifdef DATA_BUS_TARGET_COUNTER_EN
  logic [DATA_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (io_wr && (reg_sel == REG_COUNT)) cnt_d = bus.d_data_w;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_rd = cnt_q;
`else
  assign cnt_rd = '0;
`endif

  always_comb begin
    status_word                                  = '0;
    status_word[STAT_NOT_FULL]                   = !fifo_full;
    status_word[STAT_EMPTY]                      = fifo_empty;
    status_word[STAT_OVERFLOW]                   = ovf_q;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W]  = STAT_COUNT_W'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    if (!is_io) begin
      rdata = ram_q[ram_idx];
    end else begin
      case (reg_sel)
        REG_COUNT:  rdata = cnt_rd;
        REG_STATUS: rdata = status_word;
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.d_data_r  = rdata;
  assign bus.con_valid = !fifo_empty;
  assign bus.con_data  = fifo_head;

endmodule
